// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: D = A - B - BIN, one bit per clock, LSB first.
// START/BUSY/DONE handshake; D/BOUT change only when an operation completes.
//
// Handshake: START is sampled only in IDLE or DONE. An accepted START captures A/B/BIN.
// BUSY is high for exactly W cycles. DONE pulses for one cycle. D/BOUT are valid from
// the DONE cycle and are held until the next completion. START seen during RUN is dropped.
module serial_subtractor #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         BIN,
  output logic [W-1:0] D,
  output logic         BOUT,
  output logic         BUSY,
  output logic         DONE,
  output logic [1:0]   dbg_state_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sha_q, sha_d;
  logic [W-1:0]  shb_q, shb_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  d_q, d_d;
  logic          bout_q, bout_d;
  logic          brw_q, brw_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic bit_a, bit_b, diff, brw_next;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      res_q   <= res_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
    end
  end

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  assign bit_a    = sha_q[0];
  assign bit_b    = shb_q[0];
  assign diff     = bit_a ^ bit_b ^ brw_q;
  assign brw_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw_q);

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    res_d   = res_q;
    d_d     = d_q;
    bout_d  = bout_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          sha_d   = A;
          shb_d   = B;
          brw_d   = BIN;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        res_d = {diff, res_q[W-1:1]};
        sha_d = sha_q >> 1;
        shb_d = shb_q >> 1;
        brw_d = brw_next;
        cnt_d = cnt_q + 1'b1;
        // The partial result lives only in res_q; D sees the finished word.
        if (cnt_q == LAST) begin
          d_d     = {diff, res_q[W-1:1]};
          bout_d  = brw_next;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign D           = d_q;
  assign BOUT        = bout_q;
  assign BUSY        = (state_q == S_RUN);
  assign DONE        = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (W=32): results, latency, handshake, reset.
module tb_serial_subtractor;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BIN = 1'b0;
  logic [W-1:0] D;
  logic         BOUT;
  logic         BUSY;
  logic         DONE;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .BIN(BIN),
    .D(D), .BOUT(BOUT), .BUSY(BUSY), .DONE(DONE), .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Driver: START accepted at edge 0, then watch until DONE (bounded).
  // edges counts edge 0 too; outputs sampled 1 time unit after each edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] got_d, output logic got_bout,
                        output int edges, output int busy_cycles);
    @(negedge CLK);
    A = a; B = b; BIN = bin; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    edges = 1;
    busy_cycles = 0;
    while (!DONE && edges < 100) begin
      if (BUSY) busy_cycles++;
      @(posedge CLK);
      #1;
      edges++;
    end
    got_d = D;
    got_bout = BOUT;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({D, BOUT, BUSY, DONE, dbg_state} !== {{W{1'b0}}, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_state got D=%h BOUT=%b BUSY=%b DONE=%b st=%0d want all 0",
               D, BOUT, BUSY, DONE, dbg_state);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] gd; logic gb; int e, bc;
    run_op(32'd5, 32'd5, 1'b0, gd, gb, e, bc);
    checks++;
    if (e !== 33) begin failures++; $display("FAIL basic_latency got %0d want 33", e); end
    checks++;
    if (bc !== 32) begin failures++; $display("FAIL basic_busy got %0d want 32", bc); end
    checks++;
    if ({gd, gb} !== {32'h0000_0000, 1'b0}) begin
      failures++; $display("FAIL basic_result got %h/%b want 00000000/0", gd, gb);
    end
    // DONE is a single-cycle pulse, then IDLE.
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL basic_done_pulse got DONE=%b st=%0d want 0/0", DONE, dbg_state);
    end
  endtask

  task automatic test_underflow();
    logic [W-1:0] gd; logic gb; int e, bc;
    run_op(32'd3, 32'd5, 1'b0, gd, gb, e, bc);
    checks++;
    if ({gd, gb} !== {32'hFFFF_FFFE, 1'b1}) begin
      failures++; $display("FAIL underflow_3m5 got %h/%b want fffffffe/1", gd, gb);
    end
    run_op(32'd0, 32'd0, 1'b1, gd, gb, e, bc);
    checks++;
    if ({gd, gb} !== {32'hFFFF_FFFF, 1'b1}) begin
      failures++; $display("FAIL underflow_bin got %h/%b want ffffffff/1", gd, gb);
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] gd; logic gb; int e, bc;
    run_op(32'h8000_0000, 32'd1, 1'b0, gd, gb, e, bc);
    checks++;
    if ({gd, gb} !== {32'h7FFF_FFFF, 1'b0}) begin
      failures++; $display("FAIL boundary_sign got %h/%b want 7fffffff/0", gd, gb);
    end
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, gd, gb, e, bc);
    checks++;
    if ({gd, gb} !== {32'hFFFF_FFFF, 1'b1}) begin
      failures++; $display("FAIL boundary_all1 got %h/%b want ffffffff/1", gd, gb);
    end
    run_op(32'h1234_5678, 32'h0000_0678, 1'b1, gd, gb, e, bc);
    checks++;
    if ({gd, gb} !== {32'h1234_4FFF, 1'b0}) begin
      failures++; $display("FAIL boundary_mix got %h/%b want 12344fff/0", gd, gb);
    end
  endtask

  task automatic test_mid_run_start();
    int dones = 0;
    logic [W-1:0] last_d = '0;
    @(negedge CLK);
    A = 32'd100; B = 32'd30; BIN = 1'b0; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    for (int i = 1; i < 45; i++) begin
      A = $urandom; B = $urandom; BIN = 1'($urandom_range(0, 1));
      START = (i == 10 || i == 20);
      @(posedge CLK);
      #1;
      if (DONE) begin dones++; last_d = D; end
    end
    START = 1'b0;
    checks++;
    if (dones !== 1) begin failures++; $display("FAIL midrun_done_count got %0d want 1", dones); end
    checks++;
    if (last_d !== 32'd70) begin failures++; $display("FAIL midrun_result got %0d want 70", last_d); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] gd; logic gb; int e, bc;
    int held_bad = 0;
    int edges = 0;
    run_op(32'd7, 32'd2, 1'b0, gd, gb, e, bc);
    // We are inside the DONE cycle: raise START for the very next edge.
    A = 32'd10; B = 32'd4; BIN = 1'b0; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    edges = 1;
    checks++;
    if (BUSY !== 1'b1) begin failures++; $display("FAIL b2b_no_bubble got BUSY=%b want 1", BUSY); end
    while (!DONE && edges < 100) begin
      if (D !== 32'd5) held_bad++;
      @(posedge CLK);
      #1;
      edges++;
    end
    checks++;
    if (held_bad !== 0) begin failures++; $display("FAIL b2b_hold got %0d bad cycles want 0", held_bad); end
    checks++;
    if (edges !== 33) begin failures++; $display("FAIL b2b_latency got %0d want 33", edges); end
    checks++;
    if (D !== 32'd6 || BOUT !== 1'b0) begin
      failures++; $display("FAIL b2b_result got %0d/%b want 6/0", D, BOUT);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] gd; logic gb; int e, bc;
    @(negedge CLK);
    A = 32'd1000; B = 32'd1; BIN = 1'b0; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (17) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if ({D, BOUT, BUSY, DONE, dbg_state} !== {{W{1'b0}}, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL midrun_reset got D=%h BOUT=%b BUSY=%b DONE=%b st=%0d want all 0",
               D, BOUT, BUSY, DONE, dbg_state);
    end
    RST = 1'b1;
    run_op(32'd50, 32'd8, 1'b0, gd, gb, e, bc);
    checks++;
    if ({gd, gb, e} !== {32'd42, 1'b0, 33}) begin
      failures++; $display("FAIL after_reset got %0d/%b edges=%0d want 42/0 edges=33", gd, gb, e);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] gd; logic gb; int e, bc;
    logic [W-1:0] ra, rb; logic rbin;
    logic [W:0] exp_v;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
      if (i % 4 == 0) rb = ra;
      exp_v = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      run_op(ra, rb, rbin, gd, gb, e, bc);
      checks++;
      if ({gb, gd} !== exp_v || e !== 33) begin
        failures++;
        $display("FAIL random A=%h B=%h BIN=%b got %b/%h edges=%0d want %b/%h",
                 ra, rb, rbin, gb, gd, e, exp_v[W], exp_v[W-1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_boundary();
    test_mid_run_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
